frog_hop_ctrl: RTL and testbench

//  Upstream stage of the frogger_game renderer. Turns keyboard keycodes into

---
 rtl/frogger_pkg.sv | 74 +++++++
 rtl/frog_hop_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frog_hop_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared types and constants for the frogger_game frog controller: the FSM
// state and hop direction enums, the HID keycodes for W/A/S/D, the playfield
// bounds, the sprite size, and small helpers for key decoding and hop-target
// bounds checking.
// -----------------------------------------------------------------------------
package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOP  = 2'd1,
        DEAD = 2'd2
    } frog_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // USB HID usage codes
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [9:0] STEP_PX     = 10'd4;
    localparam logic [3:0] HOP_FRAMES  = 4'd5;
    localparam logic [9:0] X_START     = 10'd311;
    localparam logic [9:0] Y_START     = 10'd426;
    localparam logic [9:0] X_MIN       = 10'd0;
    localparam logic [9:0] X_MAX       = 10'd620;
    localparam logic [9:0] Y_MIN       = 10'd60;
    localparam logic [9:0] Y_MAX       = 10'd426;
    localparam logic [5:0] DEAD_FRAMES = 6'd30;
    localparam logic [9:0] FROG_SIZE   = 10'd16;

    // Full hop distance, kept 11 bits wide so bound sums never wrap.
    localparam logic [10:0] HOP_PX = 11'({1'b0, STEP_PX} * {7'd0, HOP_FRAMES});

    // Decode a keycode into {valid, dir}; unknown codes return valid=0.
    function automatic logic [2:0] decode_key(input logic [7:0] key);
        logic [2:0] res;
        case (key)
            KEY_W:   res = {1'b1, DIR_UP};
            KEY_S:   res = {1'b1, DIR_DOWN};
            KEY_A:   res = {1'b1, DIR_LEFT};
            KEY_D:   res = {1'b1, DIR_RIGHT};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // True when a full hop from (x,y) in direction d lands inside the field.
    function automatic logic hop_in_bounds(input dir_t d, input logic [9:0] x,
                                           input logic [9:0] y);
        logic [10:0] xe;
        logic [10:0] ye;
        logic        ok;
        xe = {1'b0, x};
        ye = {1'b0, y};
        case (d)
            DIR_UP:    ok = (ye >= ({1'b0, Y_MIN} + HOP_PX));
            DIR_DOWN:  ok = ((ye + HOP_PX) <= {1'b0, Y_MAX});
            DIR_LEFT:  ok = (xe >= ({1'b0, X_MIN} + HOP_PX));
            DIR_RIGHT: ok = ((xe + HOP_PX) <= {1'b0, X_MAX});
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frog_hop_ctrl.sv
// -----------------------------------------------------------------------------
// frog_hop_ctrl
// Turns keyboard keycodes into discrete, animated frog hops for the
// frogger_game renderer. A hop moves STEP_PX per frame for HOP_FRAMES frames.
// A collision freezes the frog for DEAD_FRAMES frames, then it respawns.
// All motion is paced by frame_tick; collision is sampled on every clock.
//
// Ports
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   frame_tick in   one-Clk pulse per video frame
//   keycode    in   [7:0] current HID keycode, 0 = none
//   collision  in   frog overlaps a hazard (level)
//   BallX      out  [9:0] frog X (top-left)
//   BallY      out  [9:0] frog Y (top-left)
//   BallS      out  [9:0] frog size, constant
//   hopping    out  high while a hop is in progress
//   hop_done   out  one-Clk pulse when a hop completes
//   frog_dead  out  high while frozen after a collision
// -----------------------------------------------------------------------------
module frog_hop_ctrl
    import frogger_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       collision,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic       hopping,
    output logic       hop_done,
    output logic       frog_dead
);

    // The accepting tick is already the first hop frame, so the counter is
    // loaded with the frames still to come; the hop then ends when it goes 1->0.
    localparam logic [5:0] HOP_CNT_LOAD = 6'({2'b00, HOP_FRAMES}) - 6'd1;

    frog_state_t state_r;
    frog_state_t state_nxt_s;
    dir_t        dir_r;
    dir_t        dir_nxt_s;
    dir_t        move_dir_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nxt_s;
    logic [7:0]  key_prev_r;
    logic [2:0]  key_dec_s;
    logic        key_accept_s;
    logic [9:0]  x_step_s;
    logic [9:0]  y_step_s;
    logic [9:0]  x_nxt_s;
    logic [9:0]  y_nxt_s;
    logic        hop_done_nxt_s;

    assign BallS = FROG_SIZE;

    // Key edge detection, one-frame step target and next-state selection.
    always_comb begin
        state_nxt_s    = state_r;
        dir_nxt_s      = dir_r;
        cnt_nxt_s      = cnt_r;
        x_nxt_s        = BallX;
        y_nxt_s        = BallY;
        hop_done_nxt_s = 1'b0;

        key_dec_s    = decode_key(keycode);
        key_accept_s = (keycode != 8'h00) && (keycode != key_prev_r) && key_dec_s[2];

        // In IDLE the candidate direction comes from the key; in HOP it is latched.
        if (state_r == IDLE) begin
            move_dir_s = dir_t'(key_dec_s[1:0]);
        end else begin
            move_dir_s = dir_r;
        end

        x_step_s = BallX;
        y_step_s = BallY;
        case (move_dir_s)
            DIR_UP:    y_step_s = BallY - STEP_PX;
            DIR_DOWN:  y_step_s = BallY + STEP_PX;
            DIR_LEFT:  x_step_s = BallX - STEP_PX;
            DIR_RIGHT: x_step_s = BallX + STEP_PX;
            default: begin
                x_step_s = BallX;
                y_step_s = BallY;
            end
        endcase

        case (state_r)
            IDLE: begin
                if (collision) begin
                    state_nxt_s = DEAD;
                    cnt_nxt_s   = DEAD_FRAMES;
                end else if (frame_tick && key_accept_s &&
                             hop_in_bounds(move_dir_s, BallX, BallY)) begin
                    state_nxt_s = HOP;
                    dir_nxt_s   = move_dir_s;
                    cnt_nxt_s   = HOP_CNT_LOAD;
                    x_nxt_s     = x_step_s;
                    y_nxt_s     = y_step_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOP: begin
                // Collision wins even over the final hop frame.
                if (collision) begin
                    state_nxt_s = DEAD;
                    cnt_nxt_s   = DEAD_FRAMES;
                end else if (frame_tick) begin
                    x_nxt_s = x_step_s;
                    y_nxt_s = y_step_s;
                    if (cnt_r == 6'd1) begin
                        state_nxt_s    = IDLE;
                        cnt_nxt_s      = 6'd0;
                        hop_done_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - 6'd1;
                    end
                end else begin
                    state_nxt_s = HOP;
                end
            end
            DEAD: begin
                if (frame_tick) begin
                    if (cnt_r == 6'd1) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 6'd0;
                        x_nxt_s     = X_START;
                        y_nxt_s     = Y_START;
                    end else begin
                        cnt_nxt_s = cnt_r - 6'd1;
                    end
                end else begin
                    state_nxt_s = DEAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

    // State, counter, key history and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            dir_r      <= DIR_UP;
            cnt_r      <= 6'd0;
            key_prev_r <= 8'h00;
            BallX      <= X_START;
            BallY      <= Y_START;
            hopping    <= 1'b0;
            hop_done   <= 1'b0;
            frog_dead  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dir_r     <= dir_nxt_s;
            cnt_r     <= cnt_nxt_s;
            BallX     <= x_nxt_s;
            BallY     <= y_nxt_s;
            hopping   <= (state_nxt_s == HOP);
            hop_done  <= hop_done_nxt_s;
            frog_dead <= (state_nxt_s == DEAD);
            if (frame_tick) begin
                key_prev_r <= keycode;
            end else begin
                key_prev_r <= key_prev_r;
            end
        end
    end

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_hop_ctrl
// Directed bench for frog_hop_ctrl. Each clock step pushes its expected
// outputs onto a scoreboard queue, drives inputs on the falling edge, and pops
// and compares after the rising edge. The bench tracks the frog position itself.
// -----------------------------------------------------------------------------
module tb_frog_hop_ctrl;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       h;
        logic       d;
        logic       dd;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       collision;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       hopping;
    logic       hop_done;
    logic       frog_dead;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mx;
    int   my;

    always #5 Clk = ~Clk;

    frog_hop_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .collision  (collision),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .hopping    (hopping),
        .hop_done   (hop_done),
        .frog_dead  (frog_dead)
    );

    function automatic exp_t mk(input int x, input int y, input bit h,
                                input bit d, input bit dd);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.h  = h;
        e.d  = d;
        e.dd = dd;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: queue the expectation, drive inputs, then check after the edge.
    task automatic cyc(input logic tk, input logic [7:0] k, input logic c,
                       input logic rst, input exp_t e);
        exp_t want;
        exp_q.push_back(e);
        @(negedge Clk);
        frame_tick = tk;
        keycode    = k;
        collision  = c;
        Reset      = rst;
        @(posedge Clk);
        #1;
        want = exp_q.pop_front();
        chk("BallX", BallX, want.x);
        chk("BallY", BallY, want.y);
        chk("hopping", {9'd0, hopping}, {9'd0, want.h});
        chk("hop_done", {9'd0, hop_done}, {9'd0, want.d});
        chk("frog_dead", {9'd0, frog_dead}, {9'd0, want.dd});
        chk("BallS", BallS, 10'd16);
    endtask

    // One frame: a tick clock followed by a quiet clock (hop_done must drop).
    task automatic frame(input logic [7:0] k, input logic c, input exp_t e);
        cyc(1'b1, k, c, 1'b0, e);
        e.d = 1'b0;
        cyc(1'b0, k, 1'b0, 1'b0, e);
    endtask

    // A full tapped hop: key on the first frame, released for the other four.
    task automatic do_hop(input logic [7:0] k, input int dx, input int dy);
        for (int f = 0; f < 5; f++) begin
            mx += 4 * dx;
            my += 4 * dy;
            frame((f == 0) ? k : 8'h00, 1'b0, mk(mx, my, f < 4, f == 4, 1'b0));
        end
    endtask

    // A key whose hop target is out of bounds: nothing moves.
    task automatic blocked(input logic [7:0] k);
        frame(k, 1'b0, mk(mx, my, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        frame_tick = 1'b0;
        keycode    = 8'h00;
        collision  = 1'b0;
        mx = 311;
        my = 426;

        // Reset state, then idle frames with no key.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, mk(311, 426, 0, 0, 0));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, mk(311, 426, 0, 0, 0));
        for (int i = 0; i < 3; i++) frame(8'h00, 1'b0, mk(311, 426, 0, 0, 0));

        // W held for 10 frames: one hop only, first move on the key's own tick.
        for (int f = 0; f < 10; f++) begin
            if (f < 5) my -= 4;
            frame(8'h1A, 1'b0, mk(mx, my, f < 4, f == 4, 1'b0));
        end

        // Release and press again: second hop, ends at 386.
        frame(8'h00, 1'b0, mk(mx, my, 0, 0, 0));
        do_hop(8'h1A, 0, -1);

        // Back down to the bottom edge (406->426 is exactly legal), then blocked.
        do_hop(8'h16, 0, 1);
        do_hop(8'h16, 0, 1);
        blocked(8'h16);
        // Code that is not a movement key is ignored.
        blocked(8'h10);

        // Left to x=11, where one more left hop is out of bounds.
        for (int i = 0; i < 15; i++) do_hop(8'h04, -1, 0);
        blocked(8'h04);

        // Right to x=611 (591->611 legal), then 631 would exceed 620.
        for (int i = 0; i < 30; i++) do_hop(8'h07, 1, 0);
        blocked(8'h07);

        // Up to y=66 (86->66 legal), then 46 would be under 60.
        for (int i = 0; i < 18; i++) do_hop(8'h1A, 0, -1);
        blocked(8'h1A);

        // Collision on the 3rd hop frame: frozen, no hop_done, respawn after 30 ticks.
        frame(8'h16, 1'b0, mk(611, 70, 1, 0, 0));
        frame(8'h00, 1'b0, mk(611, 74, 1, 0, 0));
        frame(8'h00, 1'b1, mk(611, 74, 0, 0, 1));
        for (int i = 1; i < 30; i++) begin
            // Collision while dead must not restart the count.
            frame(8'h00, (i == 5 || i == 10), mk(611, 74, 0, 0, 1));
        end
        frame(8'h00, 1'b0, mk(311, 426, 0, 0, 0));
        mx = 311;
        my = 426;

        // Reset mid-hop at y=414 snaps back immediately.
        frame(8'h1A, 1'b0, mk(311, 422, 1, 0, 0));
        frame(8'h00, 1'b0, mk(311, 418, 1, 0, 0));
        frame(8'h00, 1'b0, mk(311, 414, 1, 0, 0));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, mk(311, 426, 0, 0, 0));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, mk(311, 426, 0, 0, 0));
        frame(8'h00, 1'b0, mk(311, 426, 0, 0, 0));

        // Key and collision on the same tick: DEAD wins.
        frame(8'h1A, 1'b1, mk(311, 426, 0, 0, 1));
        for (int i = 1; i < 30; i++) frame(8'h00, 1'b0, mk(311, 426, 0, 0, 1));
        frame(8'h00, 1'b0, mk(311, 426, 0, 0, 0));

        // Back in IDLE: a fresh key hops; collision between ticks still kills.
        frame(8'h1A, 1'b0, mk(311, 422, 1, 0, 0));
        cyc(1'b0, 8'h00, 1'b1, 1'b0, mk(311, 422, 0, 0, 1));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, mk(311, 426, 0, 0, 0));

        chk("queue_empty", 10'(exp_q.size()), 10'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
